// File: rtl/dpram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_bist_ctrl
// Purpose  : March C- style self-test controller for a 64x8 dual-port RAM.
//            It drives the RAM write and read ports, compares the read data,
//            and reports pass/fail, an error count and the first failing
//            location.
// Ports    : clk, reset (sync, active-high)
//            start                  - test request, honoured only in IDLE
//            busy, done, pass       - run status and result
//            err_count              - saturating miscompare count
//            fail_addr/exp/data     - first miscompare details
//            mem_we/re, mem_wr_addr, mem_rd_addr, mem_wdata, mem_rdata
//                                   - RAM interface (registered outputs)
// Revision : 1.0 - initial release
// ============================================================================
module dpram_bist_ctrl #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;

  logic              we_n, re_n;
  logic [ADDR_W-1:0] aout_n;
  logic [DATA_W-1:0] wdata_n, exp_n;
  logic [DATA_W-1:0] rd_exp;

  logic              chk_v;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_addr;
  logic              mismatch;
  logic [7:0]        err_n;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // Next state and element address sequencing. Each element hands over to
  // the next one on its last address, so elements run back to back.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    case (state)
      IDLE: if (start) begin state_n = M0; addr_n = '0; end
      M0:   if (addr == LAST) begin state_n = M1; addr_n = '0; end
            else addr_n = addr + 1'b1;
      M1:   if (addr == LAST) begin state_n = M2; addr_n = '0; end
            else addr_n = addr + 1'b1;
      M2:   if (addr == LAST) begin state_n = M3; addr_n = LAST; end
            else addr_n = addr + 1'b1;
      M3:   if (addr == '0) begin state_n = M4; addr_n = LAST; end
            else addr_n = addr - 1'b1;
      M4:   if (addr == '0) begin state_n = M5; addr_n = '0; end
            else addr_n = addr - 1'b1;
      M5:   if (addr == LAST) begin state_n = DRAIN; addr_n = '0; end
            else addr_n = addr + 1'b1;
      DRAIN: state_n = DONE;
      DONE:  state_n = IDLE;
      default: begin state_n = IDLE; addr_n = '0; end
    endcase
  end

  // RAM command decode, evaluated on the next state so that the registered
  // RAM outputs line up with the state they belong to.
  always_comb begin
    we_n    = 1'b0;
    re_n    = 1'b0;
    aout_n  = '0;
    wdata_n = '0;
    exp_n   = '0;
    case (state_n)
      M0: begin we_n = 1'b1;               aout_n = addr_n; wdata_n = PATTERN; end
      M1: begin we_n = 1'b1; re_n = 1'b1;  aout_n = addr_n; wdata_n = ~PATTERN; exp_n = PATTERN;  end
      M2: begin we_n = 1'b1; re_n = 1'b1;  aout_n = addr_n; wdata_n = PATTERN;  exp_n = ~PATTERN; end
      M3: begin we_n = 1'b1; re_n = 1'b1;  aout_n = addr_n; wdata_n = ~PATTERN; exp_n = PATTERN;  end
      M4: begin we_n = 1'b1; re_n = 1'b1;  aout_n = addr_n; wdata_n = PATTERN;  exp_n = ~PATTERN; end
      M5: begin re_n = 1'b1;               aout_n = addr_n; exp_n = PATTERN; end
      default: ;
    endcase
  end

  assign mismatch = chk_v && (mem_rdata != chk_exp);
  assign err_n    = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_wdata   <= '0;
      rd_exp      <= '0;
      chk_v       <= 1'b0;
      chk_exp     <= '0;
      chk_addr    <= '0;
      err_count   <= '0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_data   <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      mem_we      <= we_n;
      mem_re      <= re_n;
      mem_wr_addr <= aout_n;
      mem_rd_addr <= aout_n;
      mem_wdata   <= wdata_n;
      rd_exp      <= exp_n;
      // Read data returns one cycle after re, so capture the read context
      // on the same edge the RAM samples the read.
      chk_v       <= mem_re;
      chk_exp     <= rd_exp;
      chk_addr    <= mem_rd_addr;
      if (state == IDLE && start) begin
        err_count <= '0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_data <= '0;
      end else begin
        err_count <= err_n;
        if (mismatch && err_count == 8'd0) begin
          fail_addr <= chk_addr;
          fail_exp  <= chk_exp;
          fail_data <= mem_rdata;
        end
        // DRAIN holds the final compare, so use the post-compare count.
        if (state == DRAIN) pass <= (err_n == 8'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_bist_ctrl
// Purpose  : Directed self-checking bench for dpram_bist_ctrl. Two
//            controllers share clk/reset/start: dut1 (PATTERN 0x55) drives a
//            behavioural RAM with an optional stuck-at-1 on bit 0 of addr 5;
//            dut2 (PATTERN 0x00) drives a RAM whose read path inverts the
//            stored data, so every read miscompares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       fault = 1'b0;

  logic       busy1, done1, pass1, we1, re1;
  logic [7:0] err1, fexp1, fdata1, wd1, rd1;
  logic [5:0] faddr1, wa1, ra1;

  logic       busy2, done2, pass2, we2, re2;
  logic [7:0] err2, fexp2, fdata2, wd2, rd2;
  logic [5:0] faddr2, wa2, ra2;

  logic [7:0] mem1 [64];
  logic [7:0] mem2 [64];

  int n_checks = 0;
  int n_fail   = 0;

  int done_cyc, done_cnt, busy_cnt, we_cnt, re_cnt, seq_err;
  logic [7:0] wd_m1, wd_m2;

  always #5 clk = ~clk;

  dpram_bist_ctrl #(.ADDR_W(6), .DATA_W(8), .PATTERN(8'h55)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_addr(faddr1), .fail_exp(fexp1), .fail_data(fdata1),
    .mem_we(we1), .mem_re(re1), .mem_wr_addr(wa1), .mem_rd_addr(ra1),
    .mem_wdata(wd1), .mem_rdata(rd1)
  );

  dpram_bist_ctrl #(.ADDR_W(6), .DATA_W(8), .PATTERN(8'h00)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_addr(faddr2), .fail_exp(fexp2), .fail_data(fdata2),
    .mem_we(we2), .mem_re(re2), .mem_wr_addr(wa2), .mem_rd_addr(ra2),
    .mem_wdata(wd2), .mem_rdata(rd2)
  );

  // RAM models: synchronous write, registered read, old data on collision.
  always @(posedge clk) begin
    if (we1) mem1[wa1] <= wd1;
    if (re1) rd1 <= mem1[ra1] | {7'd0, (fault && ra1 == 6'd5)};
    if (we2) mem2[wa2] <= wd2;
    if (re2) rd2 <= ~mem2[ra2];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut1_outs();
    return {busy1, done1, pass1, err1, faddr1, fexp1, fdata1, we1, re1, wa1, ra1, wd1};
  endfunction

  // One run: start at cycle T, observe cycles T+1..T+400. Optional start
  // pulse at cycle pulse_at and reset over cycles rst_at..rst_at+1.
  task automatic run(input int pulse_at, input int rst_at);
    int e, i;
    logic [5:0] ea;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    we_cnt = 0; re_cnt = 0; seq_err = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == rst_at + 2) check("outputs_after_reset", dut1_outs(), 64'd0);
      if (busy1) busy_cnt++;
      if (done1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (we1) we_cnt++;
      if (re1) re_cnt++;
      if (k <= 384) begin
        e  = (k - 1) / 64;
        i  = (k - 1) % 64;
        ea = (e == 3 || e == 4) ? 6'(63 - i) : 6'(i);
        if (wa1 !== ea || ra1 !== ea) seq_err++;
      end
      if (k == 65)  wd_m1 = wd1;
      if (k == 129) wd_m2 = wd1;
      start = (k == pulse_at);
      reset = (k == rst_at) || (k == rst_at + 1);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", dut1_outs(), 64'd0);
    reset = 1'b0;

    // Fault-free run plus sequencing; dut2 runs its all-miscompare case.
    run(-1, -10);
    check("t1_done_cycle", done_cyc, 386);
    check("t1_done_count", done_cnt, 1);
    check("t1_busy_cycles", busy_cnt, 385);
    check("t1_pass", pass1, 1);
    check("t1_err_count", err1, 0);
    check("t1_we_cycles", we_cnt, 320);
    check("t1_re_cycles", re_cnt, 320);
    check("t1_addr_sequence", seq_err, 0);
    check("t1_m1_wdata_addr0", wd_m1, 8'hAA);
    check("t1_m2_wdata_addr0", wd_m2, 8'h55);
    check("sat_err_count", err2, 8'd255);
    check("sat_pass", pass2, 0);
    check("sat_fail_addr", faddr2, 6'd0);
    check("sat_fail_exp", fexp2, 8'h00);
    check("sat_fail_data", fdata2, 8'hFF);

    // Stuck-at-1 on bit 0 of address 5.
    fault = 1'b1;
    run(-1, -10);
    check("t2_done_cycle", done_cyc, 386);
    check("t2_pass", pass1, 0);
    check("t2_err_count", err1, 2);
    check("t2_fail_addr", faddr1, 6'd5);
    check("t2_fail_exp", fexp1, 8'hAA);
    check("t2_fail_data", fdata1, 8'hAB);

    // Reset mid-run (after the first miscompare has already been logged).
    run(-1, 200);
    check("t3_done_count", done_cnt, 0);
    fault = 1'b0;
    run(-1, -10);
    check("t3_rerun_done_cycle", done_cyc, 386);
    check("t3_rerun_pass", pass1, 1);
    check("t3_rerun_err_count", err1, 0);

    // Start pulse while busy is ignored.
    run(100, -10);
    check("t4_done_cycle", done_cyc, 386);
    check("t4_done_count", done_cnt, 1);
    check("t4_busy_cycles", busy_cnt, 385);
    check("t4_pass", pass1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpram_bist_ctrl.md
Name: dpram_bist_ctrl

Overview:
- Initiator-side controller that drives the write and read ports of the team's 64x8 dual-port RAM.
- Runs a March C- style self-test and reports pass/fail, the first failing location and an error count.
- Sits between the test/config logic (start, results) and the RAM's we/re/addr/data pins.
- Relies on the RAM's timing contract:
  - synchronous write;
  - registered read data valid 1 cycle after re;
  - same-cycle read and write of one address returns the OLD data.

Parameters:
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- PATTERN, 8'h55, data background P; complement is ~P.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE.
- busy  out  1  high while a test is running (M0..DRAIN).
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  result; valid from done until next start.
- err_count  out  8  number of miscompares, saturates at 255.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_exp  out  DATA_W  expected data at the first miscompare.
- fail_data  out  DATA_W  read data at the first miscompare.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_wr_addr  out  ADDR_W  RAM write address.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data (1-cycle latency).

Behaviour:
- Reset:
  - state = IDLE;
  - all outputs = 0;
  - compare pipeline cleared.
  - Reset mid-test aborts immediately; RAM contents are don't-care.
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- IDLE:
  - start=1 clears err_count, pass and fail_* and enters M0 next cycle.
  - start while busy is ignored.
- Each element M0..M5 takes exactly DEPTH cycles, one address per cycle, with no bubbles between elements.
- Within an element, mem_wr_addr = mem_rd_addr = current address.
- M0 ascending: w P (we=1, re=0).
- M1 ascending: r P, w ~P (re=1, we=1 same cycle).
- M2 ascending: r ~P, w P.
- M3 descending (DEPTH-1..0): r P, w ~P.
- M4 descending: r ~P, w P.
- M5 ascending: r P only (we=0).
- Compare pipeline:
  - on each read cycle, register chk_v=1, exp, addr;
  - the next cycle compares mem_rdata against exp.
- On mismatch:
  - err_count increments, saturating at 255;
  - if err_count was 0, latch fail_addr/fail_exp/fail_data.
  - The test continues (no early abort).
- DRAIN: one cycle with we=re=0; performs the compare for M5's last read.
- DONE:
  - done=1 for one cycle; busy=0;
  - pass = (err_count==0);
  - return to IDLE.
- Timing: start seen in IDLE at cycle T gives busy high T+1..T+385, done at T+386, for DEPTH=64. General form: busy for 6*DEPTH+1 cycles.
- mem_we/mem_re/addresses/mem_wdata are registered outputs.
- Outside active cycles: we=re=0, addresses and mem_wdata = 0.
- Address counter wraps internally. The element ends when the counter reaches the last address (DEPTH-1 ascending, 0 descending).

Test Plan:
1. Fault-free RAM model, PATTERN=0x55, start at cycle T:
   - done at T+386; pass=1, err_count=0;
   - mem_we high in 320 cycles, mem_re high in 320 cycles.
2. Bit 0 of address 5 stuck-at-1 in the bench RAM:
   - pass=0, err_count=2 (M2 and M4 reads);
   - fail_addr=5, fail_exp=0xAA, fail_data=0xAB.
3. Address sequencing check:
   - M3 and M4 drive addresses 63 down to 0;
   - M0/M1/M2/M5 drive 0 to 63;
   - M1 at addr 0 has mem_wdata=0xAA; M2 at addr 0 has mem_wdata=0x55.
4. start pulsed at T+100 during a run: ignored; done still at T+386 only.
5. reset asserted at T+200, released, then start:
   - outputs all 0 after reset;
   - the new run completes with pass=1, err_count=0.
6. PATTERN=0x00, bench RAM returns 0xFF from every read:
   - err_count=255 (320 mismatches, saturates);
   - fail_addr=0, fail_exp=0x00, fail_data=0xFF.
